// File: rtl/quant_mb_sched.sv
// -----------------------------------------------------------------------------
// quant_mb_sched
//
// Macroblock-level sequencer for the 4x4 quantizer. It walks every block of one
// macroblock in coding order (Y2 first when present, then Y 0..15, then UV
// 16..23). For each block it reads the coefficients, starts the quantizer with
// the matching matrix set, and routes each result to write-back. It also builds
// a per-block non-zero mask and pulses mb_done once the last result is written.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   mb_start, i16     begin macroblock (ignored while busy); i16=1 adds Y2 block
//   busy              high from accepted mb_start through mb_done
//   coef_rd_en/addr   coefficient buffer read; data returns the next cycle
//   q_start, q_sel    quantizer start + matrix set (0=Y1, 1=Y2, 2=UV)
//   q_done, q_nz      quantizer completion and its non-zero flag
//   wb_ready          write-back credit, sampled when a block is issued
//   wb_en, wb_addr    write-back strobe and block index of the result
//   nz_mask           bit i = block i non-zero (bit 24 = Y2)
//   mb_done           one-cycle pulse, all blocks written back
// -----------------------------------------------------------------------------
module quant_mb_sched #(
   parameter int QLAT         = 2,
   parameter int MAX_INFLIGHT = 3,
   parameter int AW           = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mb_start,
   input  logic          i16,
   output logic          busy,
   output logic          coef_rd_en,
   output logic [AW-1:0] coef_rd_addr,
   output logic          q_start,
   output logic [1:0]    q_sel,
   input  logic          q_done,
   input  logic          q_nz,
   input  logic          wb_ready,
   output logic          wb_en,
   output logic [AW-1:0] wb_addr,
   output logic [24:0]   nz_mask,
   output logic          mb_done
);

   // The index FIFO must hold every result that can be in the quantizer pipe.
   localparam int FIFO_DEPTH = (MAX_INFLIGHT > QLAT + 1) ? MAX_INFLIGHT : QLAT + 1;
   localparam int PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCW        = $clog2(FIFO_DEPTH + 1);
   localparam int CW         = $clog2(MAX_INFLIGHT + 1);

   localparam logic [AW-1:0] Y2_IDX   = AW'(24);
   localparam logic [AW-1:0] UV_FIRST = AW'(16);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next_state;

   logic            r_i16;
   logic [AW-1:0]   r_pos;          // position in coding order, 0..N-1
   logic [CW-1:0]   r_cnt;          // blocks issued and not yet written back
   logic            r_q_start;
   logic [1:0]      r_q_sel;
   logic [AW-1:0]   r_q_idx;
   logic [24:0]     r_nz_mask;
   logic            r_err;          // sticky: q_done seen with nothing in flight

   logic [AW-1:0]   r_fifo [FIFO_DEPTH];
   logic [PW-1:0]   r_wp;
   logic [PW-1:0]   r_rp;
   logic [FCW-1:0]  r_fcnt;

   logic            w_active;
   logic            w_pop;
   logic            w_push;
   logic            w_room;
   logic            w_issue;
   logic            w_last;
   logic            w_drained;
   logic [AW-1:0]   w_idx;
   logic [1:0]      w_sel;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Results are only accepted while a macroblock is being processed, so
   // anything still in the quantizer pipe after a reset is discarded.
   assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_pop    = q_done && w_active && (r_fcnt != '0);
   assign w_push   = r_q_start;

   // A block written back in this very cycle frees its slot immediately,
   // which keeps back-to-back issue going when the pipe is exactly full.
   assign w_room    = (int'(r_cnt) < MAX_INFLIGHT + int'(w_pop));
   assign w_issue   = (r_state == S_RUN) && wb_ready && w_room;
   assign w_last    = (r_pos == (r_i16 ? AW'(24) : AW'(23)));
   assign w_drained = (r_cnt == CW'(w_pop));

   // With Y2 present it goes first, shifting the luma/chroma blocks by one.
   assign w_idx = r_i16 ? ((r_pos == '0) ? Y2_IDX : r_pos - AW'(1)) : r_pos;
   assign w_sel = (w_idx == Y2_IDX)   ? 2'd1 :
                  (w_idx <  UV_FIRST) ? 2'd0 : 2'd2;

   // ---------------------------------------------------------------- FSM: state
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // ----------------------------------------------------------- FSM: next state
   always_comb begin
      // NOTE: default first so no path through the case leaves it unassigned,
      // which would otherwise infer a latch.
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (mb_start)           w_next_state = S_RUN;
         S_RUN:   if (w_issue && w_last)  w_next_state = S_DRAIN;
         S_DRAIN: if (w_drained)          w_next_state = S_DONE;
         S_DONE:                          w_next_state = S_IDLE;
         default:                         w_next_state = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- FSM: outputs
   always_comb begin
      busy         = (r_state != S_IDLE);
      mb_done      = (r_state == S_DONE);
      coef_rd_en   = w_issue;
      coef_rd_addr = w_issue ? w_idx : '0;
      wb_en        = w_pop;
      wb_addr      = w_pop ? r_fifo[r_rp] : '0;
   end

   assign q_start = r_q_start;
   assign q_sel   = r_q_sel;
   assign nz_mask = r_nz_mask;

   // ------------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_i16     <= 1'b0;
         r_pos     <= '0;
         r_cnt     <= '0;
         r_q_start <= 1'b0;
         r_q_sel   <= 2'd0;
         r_q_idx   <= '0;
         r_nz_mask <= '0;
         r_err     <= 1'b0;
         r_wp      <= '0;
         r_rp      <= '0;
         r_fcnt    <= '0;
      end else begin
         if ((r_state == S_IDLE) && mb_start) begin
            r_i16     <= i16;
            r_pos     <= '0;
            r_nz_mask <= '0;
         end else if (w_issue) begin
            r_pos <= r_pos + AW'(1);
         end

         // Buffer data arrives one cycle after the read, so the start and its
         // tag are registered to line up with it.
         r_q_start <= w_issue;
         r_q_sel   <= w_issue ? w_sel : 2'd0;
         r_q_idx   <= w_issue ? w_idx : '0;

         r_cnt <= r_cnt + CW'(w_issue) - CW'(w_pop);

         if (w_push) r_wp <= ptr_inc(r_wp);
         if (w_pop)  r_rp <= ptr_inc(r_rp);
         r_fcnt <= r_fcnt + FCW'(w_push) - FCW'(w_pop);

         if (w_pop) r_nz_mask[r_fifo[r_rp]] <= q_nz;

         if (q_done && w_active && (r_fcnt == '0)) r_err <= 1'b1;
      end
   end

   // NOTE: the FIFO storage has no reset; the pointers and count define which
   // entries are valid, so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wp] <= r_q_idx;
   end

   a_no_orphan_done: assert property (@(posedge clk) disable iff (!rst_n) !r_err);

endmodule

// File: tb/tb_quant_mb_sched.sv
// -----------------------------------------------------------------------------
// tb_quant_mb_sched
//
// Self-checking bench. A behavioural model tracks the macroblock as a list of
// block indices in coding order and a per-cycle history of issued reads; from
// that it derives every expected output each cycle (read strobe/address, start
// and matrix set one cycle later, write-back three cycles after the read,
// mb_done four cycles after the last read). The quantizer itself is modelled
// as a two-cycle delay of the observed q_start.
// -----------------------------------------------------------------------------
module tb_quant_mb_sched;

   localparam int AW   = 5;
   localparam int MAXC = 16384;

   logic          clk = 1'b0;
   logic          rst_n, mb_start, i16, q_done, q_nz, wb_ready;
   logic          busy, coef_rd_en, q_start, wb_en, mb_done;
   logic [AW-1:0] coef_rd_addr, wb_addr;
   logic [1:0]    q_sel;
   logic [24:0]   nz_mask;

   always #5 clk = ~clk;

   quant_mb_sched #(.QLAT(2), .MAX_INFLIGHT(3), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .mb_start(mb_start), .i16(i16), .busy(busy),
      .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr), .q_start(q_start),
      .q_sel(q_sel), .q_done(q_done), .q_nz(q_nz), .wb_ready(wb_ready),
      .wb_en(wb_en), .wb_addr(wb_addr), .nz_mask(nz_mask), .mb_done(mb_done)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // model state
   int          rd_hist [MAXC];   // block index read in that cycle, -1 if none
   bit          qs_hist [MAXC];   // observed q_start, feeds the quantizer model
   bit          m_active;
   int          m_reads, m_last_rd, m_flush;
   int          m_order [$];
   logic [24:0] m_mask;
   int          nz_mode;

   // DUT-observed counters for the directed checks
   int dut_wb, dut_done, dut_done_cyc, run_start;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [1:0] sel_of(input int idx);
      if (idx == 24) return 2'd1;
      if (idx < 16)  return 2'd0;
      return 2'd2;
   endfunction

   function automatic bit was_read(input int c);
      return (c >= 0) && (c > m_flush) && (c < MAXC) && (rd_hist[c] >= 0);
   endfunction

   // One clock cycle: drive inputs after the edge, compare at the falling edge.
   task automatic step(input bit start, input bit s_i16, input bit rst, input bit ready);
      bit exp_rd, exp_qs, exp_wb, exp_done, was_active;
      int idx_rd, idx_qs, idx_wb;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
         $fatal(1);
      end
      exp_wb   = was_read(cyc - 3);
      idx_wb   = exp_wb ? rd_hist[cyc - 3] : 0;
      rst_n    = !rst;
      mb_start = start;
      i16      = s_i16;
      wb_ready = ready;
      q_done   = (cyc >= 2) && qs_hist[cyc - 2];
      case (nz_mode)
         0:       q_nz = 1'($urandom_range(0, 1));
         1:       q_nz = 1'b1;
         default: q_nz = exp_wb && (idx_wb == 3 || idx_wb == 17);
      endcase
      @(negedge clk);

      exp_rd   = m_active && (m_reads < m_order.size()) && ready;
      idx_rd   = exp_rd ? m_order[m_reads] : 0;
      exp_qs   = was_read(cyc - 1);
      idx_qs   = exp_qs ? rd_hist[cyc - 1] : 0;
      exp_done = m_active && (m_reads == m_order.size()) && (cyc == m_last_rd + 4);

      check("busy",         32'(busy),         32'(m_active));
      check("coef_rd_en",   32'(coef_rd_en),   32'(exp_rd));
      check("coef_rd_addr", 32'(coef_rd_addr), 32'(idx_rd));
      check("q_start",      32'(q_start),      32'(exp_qs));
      check("q_sel",        32'(q_sel),        exp_qs ? 32'(sel_of(idx_qs)) : 32'd0);
      check("wb_en",        32'(wb_en),        32'(exp_wb));
      check("wb_addr",      32'(wb_addr),      32'(idx_wb));
      check("mb_done",      32'(mb_done),      32'(exp_done));
      check("nz_mask",      32'(nz_mask),      32'(m_mask));

      if (wb_en === 1'b1) dut_wb++;
      if (mb_done === 1'b1) begin
         dut_done++;
         dut_done_cyc = cyc;
      end

      rd_hist[cyc] = exp_rd ? idx_rd : -1;
      qs_hist[cyc] = (q_start === 1'b1);
      was_active   = m_active;
      if (exp_wb)   m_mask[idx_wb] = q_nz;
      if (exp_rd)   begin m_reads++; m_last_rd = cyc; end
      if (exp_done) m_active = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         m_mask   = '0;
         m_reads  = 0;
         m_order.delete();
         m_flush  = cyc;
      end else if (start && !was_active) begin
         m_active = 1'b1;
         m_mask   = '0;
         m_reads  = 0;
         m_order.delete();
         if (s_i16) m_order.push_back(24);
         for (int i = 0; i < 24; i++) m_order.push_back(i);
      end
   endtask

   // One macroblock. Relative cycle 0 carries mb_start; wb_ready is held low
   // over [lo_from, lo_to]; restart_at pulses a second mb_start; rst_at
   // asserts reset for one cycle and ends the run a few cycles later.
   task automatic run_mb(input bit s_i16, input int mode, input int lo_from, input int lo_to,
                         input int restart_at, input int rst_at, input int rdy_pct);
      int d0;
      bit rdy;
      d0      = dut_done;
      nz_mode = mode;
      for (int rel = 0; rel < 300; rel++) begin
         rdy = (rel >= lo_from && rel <= lo_to) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
         step(rel == 0 || rel == restart_at, (rel == 0) ? s_i16 : !s_i16, rel == rst_at, rdy);
         if (rel == 0) run_start = cyc;
         if (dut_done != d0) break;
         if (rst_at >= 0 && rel >= rst_at + 6) break;
      end
      if (rst_at < 0) check("run_completes", 32'(dut_done - d0), 32'd1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
   endtask

   initial begin
      int w0;
      rst_n = 1'b0; mb_start = 1'b0; i16 = 1'b0;
      q_done = 1'b0; q_nz = 1'b0; wb_ready = 1'b0;
      for (int i = 0; i < MAXC; i++) begin rd_hist[i] = -1; qs_hist[i] = 1'b0; end
      m_active = 1'b0; m_reads = 0; m_last_rd = -100; m_flush = -1; m_mask = '0;
      nz_mode = 0; dut_wb = 0; dut_done = 0; dut_done_cyc = 0; run_start = 0;
      repeat (3) @(posedge clk);

      // reset state
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      step(1'b0, 1'b1, 1'b0, 1'b1);

      // 24 blocks, continuous credit
      w0 = dut_wb;
      run_mb(0, 0, -1, -1, -1, -1, 100);
      check("t1_done_latency", 32'(dut_done_cyc - run_start), 32'd28);
      check("t1_wb_count",     32'(dut_wb - w0),              32'd24);

      // 25 blocks, all non-zero
      w0 = dut_wb;
      run_mb(1, 1, -1, -1, -1, -1, 100);
      check("t2_done_latency", 32'(dut_done_cyc - run_start), 32'd29);
      check("t2_wb_count",     32'(dut_wb - w0),              32'd25);
      check("t2_nz_mask",      32'(nz_mask),                  32'h01FF_FFFF);

      // only blocks 3 and 17 non-zero
      run_mb(0, 2, -1, -1, -1, -1, 100);
      check("t3_nz_mask", 32'(nz_mask), 32'h0002_0008);

      // credit withdrawn for five cycles
      run_mb(0, 0, 5, 9, -1, -1, 100);
      check("t4_done_latency", 32'(dut_done_cyc - run_start), 32'd33);

      // second mb_start mid-run is ignored
      w0 = dut_wb;
      run_mb(0, 0, -1, -1, 10, -1, 100);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("t5_wb_count", 32'(dut_wb - w0), 32'd24);
      check("t5_busy_idle", 32'(busy), 32'd0);

      // reset mid-run drops in-flight results, then a clean macroblock
      w0 = dut_wb;
      run_mb(0, 0, -1, -1, -1, 12, 100);
      check("t6_wb_before_reset", 32'(dut_wb - w0), 32'd9);
      check("t6_nz_cleared",      32'(nz_mask),     32'd0);
      check("t6_busy_cleared",    32'(busy),        32'd0);
      run_mb(0, 0, -1, -1, -1, -1, 100);
      check("t6_fresh_latency", 32'(dut_done_cyc - run_start), 32'd28);

      // randomized macroblocks
      for (int r = 0; r < 20; r++) begin
         w0 = dut_wb;
         run_mb(1'($urandom_range(0, 1)), 0, -1, -1, int'($urandom_range(1, 40)), -1, 70);
         check("rnd_wb_count", 32'(dut_wb - w0), 32'(m_order.size()));
         repeat (int'($urandom_range(0, 3))) step(0, 0, 0, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/quant_mb_sched.md
Name: quant_mb_sched

Overview:
- Macroblock-level sequencer for the 4x4 quantizer datapath (2-cycle, non-stallable pipeline with start/done, nz flag).
- Walks all blocks of one macroblock in coding order and fetches each block's coefficients from the transform buffer.
- Per block, selects the quant matrix set (Y1/Y2/UV), issues quantizer starts back-to-back, and routes results to write-back.
- Accumulates a per-block non-zero mask and signals macroblock completion to the top-level encoder FSM.

Parameters:
- QLAT, 2, quantizer start-to-done latency in cycles
- MAX_INFLIGHT, 3, maximum blocks issued and not yet written back (QLAT+1)
- AW, 5, block index / buffer address width

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- mb_start  input  1  one-cycle pulse, begin macroblock; ignored while busy
- i16  input  1  sampled with mb_start; 1 = Y2 block present (25 blocks), 0 = 24 blocks
- busy  output  1  high from accepted mb_start until mb_done inclusive
- coef_rd_en  output  1  coefficient buffer read strobe; data returns next cycle
- coef_rd_addr  output  AW  block index read
- q_start  output  1  quantizer start, aligned with coefficient buffer output data
- q_sel  output  2  matrix set for the issued block: 0 = Y1, 1 = Y2, 2 = UV; 3 is never driven
- q_done  input  1  quantizer done
- q_nz  input  1  quantizer non-zero flag, valid with q_done
- wb_ready  input  1  write-back credit; sampled at issue time
- wb_en  output  1  write-back strobe (equal to q_done while RUN/DRAIN)
- wb_addr  output  AW  block index of the result being written
- nz_mask  output  25  bit i = block i non-zero; bit 24 = Y2
- mb_done  output  1  one-cycle pulse, all blocks written back

Behaviour:
- Reset (rst_n low at a clock edge):
  - State returns to IDLE; counters and index FIFO are cleared.
  - All outputs go to 0; nz_mask = 0.
  - In-flight results are dropped: q_done received in IDLE is ignored and produces no wb_en.
- Block order and matrix select:
  - i16=1: index 24 (q_sel=1), then 0..15 (q_sel=0), then 16..23 (q_sel=2).
  - i16=0: 0..15 (q_sel=0), then 16..23 (q_sel=2).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on mb_start: latch i16, clear nz_mask, busy=1.
  - RUN: each cycle with wb_ready=1 and inflight<MAX_INFLIGHT, assert coef_rd_en with the next index. No issue (bubble) otherwise.
  - RUN -> DRAIN in the cycle after the last read is issued.
  - DRAIN -> DONE when inflight reaches 0.
  - DONE: mb_done=1 for one cycle, then IDLE. busy falls the cycle after mb_done.
- Issue pipeline:
  - A read at cycle t gives q_start=1 at t+1, with q_sel and the index registered alongside.
  - The index is pushed into a MAX_INFLIGHT-deep index FIFO at q_start.
- Completion:
  - On q_done, pop the FIFO: wb_en=1, wb_addr = popped index, nz_mask[index] <= q_nz.
  - inflight increments on coef_rd_en and decrements on q_done. A simultaneous increment and decrement leaves it unchanged.
- Credit rule: the downstream must accept wb_en QLAT+1 cycles after the wb_ready it sampled. The scheduler never stalls results.
- nz_mask holds its value after DONE until the next accepted mb_start.
- Error handling:
  - q_done with an empty FIFO is ignored (sticky internal error flag for assertions).
  - mb_start while busy has no effect.

Test Plan:
- i16=0, wb_ready=1, mb_start at cycle 0:
  - reads at cycles 1..24 with addr 0..23.
  - q_sel is 0 for the first 16 starts and 2 for the next 8.
  - wb_en at cycles 4..27; mb_done at cycle 28; busy low at 29.
- i16=1, all q_nz=1:
  - first coef_rd_addr=24 with q_sel=1, then 0..23.
  - 25 wb_en pulses; nz_mask = 0x1FFFFFF; mb_done at cycle 29.
- i16=0, q_nz=1 only for blocks 3 and 17 -> nz_mask = 0x0020008 at mb_done.
- wb_ready low for cycles 5..9 -> no coef_rd_en in cycles 5..9; order preserved; mb_done delayed by exactly 5 cycles (cycle 33).
- mb_start pulsed again at cycle 10 of a run -> ignored; exactly 24 wb_en pulses, single mb_done.
- rst_n low for one cycle at cycle 12:
  - all outputs 0 next cycle; no wb_en despite in-flight q_done; nz_mask = 0.
  - a fresh mb_start then completes normally.
